// File: rtl/ccr_branch_unit.sv
// rtl/ccr_branch_unit.sv - condition-code register, interrupt shadow and branch resolution unit.
// Conditions are evaluated on the registered CCR; a taken branch emits a one-cycle redirect/flush pulse.
module ccr_branch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  alu_flags,
    input  logic        flags_we,
    input  logic        setc,
    input  logic        clrc,
    input  logic [2:0]  jmp_type,
    input  logic [15:0] target,
    input  logic        int_save,
    input  logic        rti_restore,
    input  logic        stall,
    output logic [2:0]  ccr,
    output logic        branch_taken,
    output logic [15:0] branch_pc,
    output logic        flush,
    output logic        shadow_valid,
    output logic        nest_err
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ccr_q, ccr_d;
    logic [2:0]  shadow_q, shadow_d;
    logic        shadow_valid_q, shadow_valid_d;
    logic        nest_err_q, nest_err_d;
    logic        branch_taken_q, branch_taken_d;
    logic        flush_q, flush_d;
    logic [15:0] branch_pc_q, branch_pc_d;

    logic        cond;
    logic        taken;
    logic [2:0]  clr_mask;

    always_comb begin
        state_d        = state_q;
        ccr_d          = ccr_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        nest_err_d     = nest_err_q;
        branch_taken_d = branch_taken_q;
        flush_d        = flush_q;
        branch_pc_d    = branch_pc_q;
        cond           = 1'b0;
        taken          = 1'b0;
        clr_mask       = 3'b000;

        case (jmp_type)
            3'b001: begin cond = ccr_q[0]; clr_mask = 3'b001; end
            3'b010: begin cond = ccr_q[1]; clr_mask = 3'b010; end
            3'b011: begin cond = ccr_q[2]; clr_mask = 3'b100; end
            3'b100: cond = 1'b1;
            default: cond = 1'b0;
        endcase

        if (!stall) begin
            // The instruction seen in FLUSH is on the wrong path, so its jump is dropped.
            taken          = (state_q == ST_RUN) && cond;
            branch_taken_d = taken;
            flush_d        = taken;
            state_d        = taken ? ST_FLUSH : ST_RUN;
            if (taken) begin
                branch_pc_d = target;
            end

            // Apply CCR writers lowest priority first so higher ones overwrite.
            if (taken) begin
                ccr_d = ccr_q & ~clr_mask;
            end
            if (clrc) begin
                ccr_d[2] = 1'b0;
            end
            if (setc) begin
                ccr_d[2] = 1'b1;
            end
            if (flags_we) begin
                ccr_d = alu_flags;
            end
            if (rti_restore && shadow_valid_q) begin
                ccr_d = shadow_q;
            end

            // A simultaneous save wins the valid bit: the restore consumes the old shadow first.
            if (int_save) begin
                shadow_d       = ccr_q;
                shadow_valid_d = 1'b1;
                if (shadow_valid_q) begin
                    nest_err_d = 1'b1;
                end
            end else if (rti_restore && shadow_valid_q) begin
                shadow_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            ccr_q          <= 3'b000;
            shadow_q       <= 3'b000;
            shadow_valid_q <= 1'b0;
            nest_err_q     <= 1'b0;
            branch_taken_q <= 1'b0;
            flush_q        <= 1'b0;
            branch_pc_q    <= 16'h0000;
        end else begin
            state_q        <= state_d;
            ccr_q          <= ccr_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            nest_err_q     <= nest_err_d;
            branch_taken_q <= branch_taken_d;
            flush_q        <= flush_d;
            branch_pc_q    <= branch_pc_d;
        end
    end

    assign ccr          = ccr_q;
    assign branch_taken = branch_taken_q;
    assign branch_pc    = branch_pc_q;
    assign flush        = flush_q;
    assign shadow_valid = shadow_valid_q;
    assign nest_err     = nest_err_q;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// tb/tb_ccr_branch_unit.sv - directed and randomized self-checking bench for ccr_branch_unit.
module tb_ccr_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  alu_flags;
    logic        flags_we, setc, clrc;
    logic [2:0]  jmp_type;
    logic [15:0] target;
    logic        int_save, rti_restore, stall;
    logic [2:0]  ccr;
    logic        branch_taken;
    logic [15:0] branch_pc;
    logic        flush, shadow_valid, nest_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: architectural view only.
    logic [2:0]  m_ccr, m_shadow;
    logic        m_sv, m_err, m_pulse;
    logic [15:0] m_pc;

    ccr_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .alu_flags(alu_flags), .flags_we(flags_we),
        .setc(setc), .clrc(clrc), .jmp_type(jmp_type), .target(target),
        .int_save(int_save), .rti_restore(rti_restore), .stall(stall),
        .ccr(ccr), .branch_taken(branch_taken), .branch_pc(branch_pc),
        .flush(flush), .shadow_valid(shadow_valid), .nest_err(nest_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ccr", {13'd0, ccr}, {13'd0, m_ccr});
        chk("branch_taken", {15'd0, branch_taken}, {15'd0, m_pulse});
        chk("flush", {15'd0, flush}, {15'd0, m_pulse});
        chk("branch_pc", branch_pc, m_pc);
        chk("shadow_valid", {15'd0, shadow_valid}, {15'd0, m_sv});
        chk("nest_err", {15'd0, nest_err}, {15'd0, m_err});
    endtask

    task automatic model_reset();
        m_ccr = 3'b000; m_shadow = 3'b000; m_sv = 1'b0; m_err = 1'b0;
        m_pulse = 1'b0; m_pc = 16'h0000;
    endtask

    task automatic idle();
        alu_flags = 3'b000; flags_we = 0; setc = 0; clrc = 0; jmp_type = 3'b000;
        target = 16'h0000; int_save = 0; rti_restore = 0; stall = 0;
    endtask

    // One clock: predict from the current inputs, advance, then compare everything.
    task automatic tick();
        logic [2:0]  n_ccr, n_shadow;
        logic        n_sv, n_err, n_pulse, cond_true;
        logic [15:0] n_pc;
        int          jt;
        n_ccr = m_ccr; n_shadow = m_shadow; n_sv = m_sv; n_err = m_err;
        n_pulse = m_pulse; n_pc = m_pc;
        jt = int'(jmp_type);
        if (!stall) begin
            if (jt >= 1 && jt <= 3) cond_true = m_ccr[jt-1];
            else                    cond_true = (jt == 4);
            // A pulse currently showing means we sit in the one flush cycle.
            n_pulse = cond_true && !m_pulse;
            if (n_pulse) n_pc = target;
            if (n_pulse && jt >= 1 && jt <= 3) n_ccr[jt-1] = 1'b0;
            if (clrc) n_ccr[2] = 1'b0;
            if (setc) n_ccr[2] = 1'b1;
            if (flags_we) n_ccr = alu_flags;
            if (rti_restore && m_sv) begin
                n_ccr = m_shadow;
                n_sv  = 1'b0;
            end
            if (int_save) begin
                n_shadow = m_ccr;
                n_sv     = 1'b1;
                n_err    = m_err | m_sv;
            end
        end
        @(posedge clk);
        #1;
        m_ccr = n_ccr; m_shadow = n_shadow; m_sv = n_sv; m_err = n_err;
        m_pulse = n_pulse; m_pc = n_pc;
        check_all();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        chk("reset_ccr", {13'd0, ccr}, 16'h0000);
        rst_n = 1'b1;

        // JZ on registered Z flag
        flags_we = 1; alu_flags = 3'b001; tick();
        idle(); jmp_type = 3'b001; target = 16'h00A4; tick();
        chk("jz_pulse", {15'd0, branch_taken}, 16'h0001);
        chk("jz_pc", branch_pc, 16'h00A4);
        chk("jz_ccr", {13'd0, ccr}, 16'h0000);
        idle(); tick();

        // JC not taken, then setc, then JC taken
        jmp_type = 3'b011; target = 16'h0777; tick();
        chk("jc_nt", {15'd0, branch_taken}, 16'h0000);
        idle(); setc = 1; tick();
        idle(); jmp_type = 3'b011; target = 16'h0010; tick();
        chk("jc_pc", branch_pc, 16'h0010);
        chk("jc_ccr", {13'd0, ccr}, 16'h0000);
        idle(); tick();

        // JMP with a wrong-path jump in the flush cycle
        jmp_type = 3'b100; target = 16'h1234; tick();
        jmp_type = 3'b100; target = 16'h5555; tick();
        chk("wrongpath_pulse", {15'd0, branch_taken}, 16'h0000);
        chk("wrongpath_pc", branch_pc, 16'h1234);
        idle(); tick();

        // setc and clrc together leave carry set
        setc = 1; clrc = 1; tick();
        chk("setc_clrc", {15'd0, ccr[2]}, 16'h0001);
        idle();

        // Shadow save/restore and nesting error
        flags_we = 1; alu_flags = 3'b110; tick();
        idle(); int_save = 1; tick();
        idle(); flags_we = 1; alu_flags = 3'b001; tick();
        idle(); rti_restore = 1; tick();
        chk("rti_ccr", {13'd0, ccr}, 16'h0006);
        chk("rti_sv", {15'd0, shadow_valid}, 16'h0000);
        rti_restore = 1; flags_we = 1; alu_flags = 3'b010; tick();
        chk("rti_noshadow", {15'd0, nest_err}, 16'h0000);
        idle(); int_save = 1; tick();
        int_save = 1; tick();
        chk("nest_err", {15'd0, nest_err}, 16'h0001);
        idle(); int_save = 1; rti_restore = 1; tick();
        chk("save_restore_sv", {15'd0, shadow_valid}, 16'h0001);
        idle(); tick();

        // JZ taken while flags_we writes; stall the flush cycle
        flags_we = 1; alu_flags = 3'b001; tick();
        idle(); jmp_type = 3'b001; target = 16'h0BEE; flags_we = 1; alu_flags = 3'b011; tick();
        chk("jz_fwe_ccr", {13'd0, ccr}, 16'h0003);
        idle(); stall = 1; jmp_type = 3'b100; setc = 1; int_save = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pulse", {15'd0, branch_taken}, 16'h0001);
        end
        idle(); tick();
        chk("after_stall", {15'd0, flush}, 16'h0000);

        // Asynchronous reset in the middle of a flush cycle
        flags_we = 1; alu_flags = 3'b111; int_save = 1; tick();
        idle(); jmp_type = 3'b100; target = 16'hBEEF; tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3 rst_n = 1'b1;
        jmp_type = 3'b100; target = 16'h0002; tick();
        chk("post_reset_pc", branch_pc, 16'h0002);
        idle(); tick();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            alu_flags   = 3'($urandom);
            flags_we    = ($urandom_range(0, 3) == 0);
            setc        = ($urandom_range(0, 5) == 0);
            clrc        = ($urandom_range(0, 5) == 0);
            jmp_type    = 3'($urandom);
            target      = 16'($urandom);
            int_save    = ($urandom_range(0, 7) == 0);
            rti_restore = ($urandom_range(0, 5) == 0);
            stall       = ($urandom_range(0, 7) == 0);
            tick();
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                #3 rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
